// File: rtl/canvas_reader_pkg.sv
// Shared types and constants for the canvas_reader block: colour codes,
// write-FSM states and canvas geometry.
package canvas_reader_pkg;

  localparam int CELL_SHIFT_DEF   = 2;
  localparam int CANVAS_W_DEF     = 160;
  localparam int CANVAS_H_DEF     = 120;
  localparam int BRUSH_RADIUS_DEF = 2;
  localparam int CANVAS_CELLS     = CANVAS_W_DEF * CANVAS_H_DEF;
  localparam int CANVAS_AW        = 15;

  typedef enum logic [2:0] {
    RED    = 3'd0,
    GREEN  = 3'd1,
    BLUE   = 3'd2,
    YELLOW = 3'd3,
    PURPLE = 3'd4,
    WHITE  = 3'd5,
    ERASE  = 3'd6
  } colorCode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAINT,
    ST_CLEAR
  } wr_state_t;

  // Row-major cell address for a 160-cell-wide canvas: cy*160 + cx without a multiplier.
  function automatic logic [CANVAS_AW-1:0] cell_addr(input logic [7:0] cx, input logic [7:0] cy);
    logic [CANVAS_AW-1:0] cy_w;
    cy_w = {7'b0, cy};
    return (cy_w << 7) + (cy_w << 5) + {7'b0, cx};
  endfunction

endpackage

// File: rtl/canvas_reader_ram.sv
// canvasRam: simple dual-port 19200x3 canvas store, one synchronous
// read-first read port and one write port.
module canvasRam
  import canvas_reader_pkg::*;
#(
  parameter int DEPTH = CANVAS_CELLS,
  parameter int AW    = CANVAS_AW,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM; the owner clears it by writing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/canvas_reader.sv
// canvas_reader: pixel-aligned canvas fetch with brush overlay plus a
// paint/clear write FSM. Define CANVAS_CURSOR_EN to build the brush overlay.
module canvas_reader
  import canvas_reader_pkg::*;
#(
  parameter int CELL_SHIFT   = CELL_SHIFT_DEF,
  parameter int CANVAS_W     = CANVAS_W_DEF,
  parameter int CANVAS_H     = CANVAS_H_DEF,
  parameter int BRUSH_RADIUS = BRUSH_RADIUS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       visible,
  input  logic [7:0] brushX,
  input  logic [6:0] brushY,
  input  logic       paintValid,
  input  logic [2:0] paintColor,
  output logic       paintReady,
  input  logic       clearReq,
  output logic       busy,
  output logic       brush,
  output logic [2:0] colorCode,
  output logic       pixValid
);

  localparam int                 CELLS = CANVAS_W * CANVAS_H;
  localparam logic signed [9:0]  RAD   = 10'(BRUSH_RADIUS);
  localparam logic signed [9:0]  W10   = 10'(CANVAS_W);
  localparam logic signed [9:0]  H10   = 10'(CANVAS_H);
  localparam logic [CANVAS_AW-1:0] LAST_ADDR = CANVAS_AW'(CELLS - 1);

  // ---------------- read path ----------------
  logic [7:0]           rd_cx, rd_cy;
  logic [CANVAS_AW-1:0] raddr;
  logic [2:0]           rdata;
  logic                 vis_d1, vis_d2;
  logic                 unused_px;

  assign rd_cx     = x[9:CELL_SHIFT];
  assign rd_cy     = y[9:CELL_SHIFT];
  assign unused_px = ^{x[CELL_SHIFT-1:0], y[CELL_SHIFT-1:0]};

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr  <= '0;
      vis_d1 <= 1'b0;
      vis_d2 <= 1'b0;
    end else begin
      raddr  <= visible ? cell_addr(rd_cx, rd_cy) : '0;
      vis_d1 <= visible;
      vis_d2 <= vis_d1;
    end
  end

  assign pixValid  = vis_d2;
  assign colorCode = vis_d2 ? rdata : ERASE;

`ifdef CANVAS_CURSOR_EN
  logic signed [9:0] bdx, bdy;
  logic              brush_hit, brush_d1, brush_d2;

  assign bdx       = $signed({2'b0, rd_cx}) - $signed({2'b0, brushX});
  assign bdy       = $signed({2'b0, rd_cy}) - $signed({3'b0, brushY});
  assign brush_hit = visible && (bdx >= -RAD) && (bdx <= RAD) && (bdy >= -RAD) && (bdy <= RAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brush_d1 <= 1'b0;
      brush_d2 <= 1'b0;
    end else begin
      brush_d1 <= brush_hit;
      brush_d2 <= brush_d1;
    end
  end

  assign brush = brush_d2 & vis_d2;
`else
  assign brush = 1'b0;
`endif

  // ---------------- write FSM ----------------
  wr_state_t            state, state_n;
  logic [CANVAS_AW-1:0] clr_cnt;
  logic signed [9:0]    pdx, pdy;
  logic [7:0]           lat_x;
  logic [6:0]           lat_y;
  logic [2:0]           lat_c;
  logic signed [9:0]    pcx, pcy;
  logic                 in_range, last_cell, accept;
  logic                 we;
  logic [CANVAS_AW-1:0] waddr;
  logic [2:0]           wdata;

  assign pcx       = $signed({2'b0, lat_x}) + pdx;
  assign pcy       = $signed({3'b0, lat_y}) + pdy;
  assign in_range  = (pcx >= 10'sd0) && (pcx < W10) && (pcy >= 10'sd0) && (pcy < H10);
  assign last_cell = (pdx == RAD) && (pdy == RAD);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    we         = 1'b0;
    waddr      = clr_cnt;
    wdata      = ERASE;
    paintReady = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        paintReady = !clearReq;
        if (clearReq) begin
          state_n = ST_CLEAR;
        end else if (paintValid) begin
          accept  = 1'b1;
          state_n = ST_PAINT;
        end
      end
      ST_PAINT: begin
        we    = in_range;
        waddr = cell_addr(pcx[7:0], pcy[7:0]);
        wdata = lat_c;
        if (last_cell) state_n = ST_IDLE;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        we   = 1'b1;
        if (clr_cnt == LAST_ADDR) state_n = ST_IDLE;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  // Reset lands in CLEAR because the RAM powers up with undefined contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      pdx     <= -RAD;
      pdy     <= -RAD;
      lat_x   <= '0;
      lat_y   <= '0;
      lat_c   <= '0;
    end else begin
      state <= state_n;
      if (state == ST_CLEAR)
        clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
      if (accept) begin
        lat_x <= brushX;
        lat_y <= brushY;
        lat_c <= paintColor;
        pdx   <= -RAD;
        pdy   <= -RAD;
      end else if (state == ST_PAINT) begin
        if (pdx == RAD) begin
          pdx <= -RAD;
          pdy <= pdy + 10'sd1;
        end else begin
          pdx <= pdx + 10'sd1;
        end
      end
    end
  end

  canvasRam u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_canvas_reader.sv
// Scoreboard bench for canvas_reader: random reads/paints against a
// cell-array model; a separate monitor pops expectations at output time.
module tb_canvas_reader;
  import canvas_reader_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       visible;
  logic [7:0] brushX;
  logic [6:0] brushY;
  logic       paintValid;
  logic [2:0] paintColor;
  logic       paintReady;
  logic       clearReq;
  logic       busy;
  logic       brush;
  logic [2:0] colorCode;
  logic       pixValid;

  always #5 clk = ~clk;

  canvas_reader dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .visible    (visible),
    .brushX     (brushX),
    .brushY     (brushY),
    .paintValid (paintValid),
    .paintColor (paintColor),
    .paintReady (paintReady),
    .clearReq   (clearReq),
    .busy       (busy),
    .brush      (brush),
    .colorCode  (colorCode),
    .pixValid   (pixValid)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic       pv;
    logic [2:0] cc;
    logic       br;
  } exp_t;

  exp_t     sb[$];
  bit [2:0] cmodel [160][120];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        cmodel[i][j] = ERASE;
  endfunction

  function automatic void model_paint(input int bx, input int by, input bit [2:0] c);
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        if (bx + dx >= 0 && bx + dx < 160 && by + dy >= 0 && by + dy < 120)
          cmodel[bx + dx][by + dy] = c;
  endfunction

  function automatic bit exp_brush(input int px, input int py, input bit vis, input int bx, input int by);
`ifdef CANVAS_CURSOR_EN
    int dx, dy;
    dx = (px / 4) - bx;
    dy = (py / 4) - by;
    return vis && dx >= -2 && dx <= 2 && dy >= -2 && dy <= 2;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          check("sb_timing", cyc, e.due);
        end else begin
          check("pixValid", pixValid, e.pv);
          check("colorCode", colorCode, e.cc);
          check("brush", brush, e.br);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic rd(input int px, input int py, input bit vis, input int bx, input int by);
    exp_t e;
    @(negedge clk);
    x       = 10'(px);
    y       = 10'(py);
    visible = vis;
    brushX  = 8'(bx);
    brushY  = 7'(by);
    e.due = cyc + 2;
    e.pv  = vis;
    e.cc  = vis ? cmodel[px / 4][py / 4] : ERASE;
    e.br  = exp_brush(px, py, vis, bx, by);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic wait_clear(input string name, input bit pulse);
    int n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (pulse && n == 500) clearReq = 1'b1;
      if (pulse && n == 501) clearReq = 1'b0;
      if (n == 1000) check({name, "_ready_low"}, paintReady, 0);
    end
    check(name, n, 19200);
  endtask

  task automatic paint(input int bx, input int by, input bit [2:0] c, input bit pulse_clr);
    int n = 0;
    drain();
    @(negedge clk);
    brushX     = 8'(bx);
    brushY     = 7'(by);
    paintColor = c;
    paintValid = 1'b1;
    #1;
    check("paint_ready_idle", paintReady, 1);
    @(posedge clk);
    #1;
    paintValid = 1'b0;
    while (paintReady !== 1'b1 && n < 100) begin
      if (pulse_clr && n == 5) clearReq = 1'b1;
      if (pulse_clr && n == 6) clearReq = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check("paint_latency", n, 25);
    check("paint_busy_low", busy, 0);
    model_paint(bx, by, c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; x = '0; y = '0; visible = 1'b0; brushX = '0; brushY = '0;
    paintValid = 1'b0; paintColor = '0; clearReq = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst_brush", brush, 0);
    check("rst_colorCode", colorCode, ERASE);
    check("rst_pixValid", pixValid, 0);
    check("rst_paintReady", paintReady, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("post_rst_busy", busy, 1);
    wait_clear("clear_after_reset", 1'b0);
    check("ready_after_clear", paintReady, 1);

    for (int i = 0; i < 16; i++)
      rd($urandom_range(639), $urandom_range(479), 1'b1, 0, 0);

    // Brush at (10,10) in RED.
    paint(10, 10, RED, 1'b0);
    rd(32, 32, 1'b1, 10, 10);
    rd(52, 32, 1'b1, 10, 10);
    rd(48, 48, 1'b1, 10, 10);
    rd(31, 40, 1'b1, 10, 10);
    rd(40, 30, 1'b1, 10, 10);

    // Corner footprint clipped to 3x3; clearReq during the sweep is ignored.
    paint(0, 0, BLUE, 1'b1);
    rd(0, 0, 1'b1, 0, 0);
    rd(11, 11, 1'b1, 0, 0);
    rd(12, 0, 1'b1, 0, 0);
    rd(632, 472, 1'b1, 0, 0);
    rd(639, 479, 1'b1, 0, 0);

    // Far corner: no wrap-around into column/row 0.
    paint(159, 119, GREEN, 1'b0);
    rd(636, 476, 1'b1, 159, 119);
    rd(628, 468, 1'b1, 159, 119);
    rd(0, 476, 1'b1, 159, 119);
    rd(636, 0, 1'b1, 159, 119);

    // Cursor overlay and blanking.
    rd(320, 240, 1'b1, 80, 60);
    rd(340, 240, 1'b1, 80, 60);
    rd(311, 255, 1'b1, 80, 60);
    rd(320, 240, 1'b0, 80, 60);
    rd(100, 100, 1'b0, 25, 25);

    for (int p = 0; p < 8; p++) begin
      paint($urandom_range(170), $urandom_range(127), 3'($urandom_range(5)), 1'b0);
      for (int i = 0; i < 30; i++) begin
        int px, py, bx, by;
        px = $urandom_range(639);
        py = $urandom_range(479);
        bx = (px / 4) + $urandom_range(6) - 3;
        by = (py / 4) + $urandom_range(6) - 3;
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
        if (by > 127) by = 127;
        rd(px, py, ($urandom_range(7) != 0), bx, by);
      end
    end
    drain();

    // Simultaneous clearReq and paintValid: clear wins, paint dropped.
    @(negedge clk);
    brushX = 8'd50; brushY = 7'd50; paintColor = YELLOW;
    paintValid = 1'b1; clearReq = 1'b1;
    #1;
    check("clr_paint_ready", paintReady, 0);
    @(posedge clk);
    #1;
    paintValid = 1'b0; clearReq = 1'b0;
    check("clr_busy_enter", busy, 1);
    wait_clear("clear_after_req", 1'b1);
    model_clear();
    check("ready_after_req_clear", paintReady, 1);
    rd(40, 40, 1'b1, 10, 10);
    rd(200, 200, 1'b1, 50, 50);
    rd(0, 0, 1'b1, 0, 0);
    rd(636, 476, 1'b1, 0, 0);

    // Reset 10 cycles into a paint.
    drain();
    @(negedge clk);
    brushX = 8'd20; brushY = 7'd20; paintColor = WHITE; paintValid = 1'b1;
    @(posedge clk);
    #1;
    paintValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midpaint_rst_busy", busy, 1);
    check("midpaint_rst_ready", paintReady, 0);
    check("midpaint_rst_pixValid", pixValid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clear_after_midpaint_reset", 1'b0);
    model_clear();
    for (int i = 0; i < 5; i++)
      rd(72 + 4 * i, 72 + 4 * i, 1'b1, 0, 0);
    rd(80, 88, 1'b1, 20, 20);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/canvas_reader.md
# canvas_reader

Per-pixel fetch stage feeding the colour decoder. It holds the 160×120 canvas of 3-bit colour codes, one code per 4×4-pixel cell, in dual-port block RAM. For each VGA pixel it produces `colorCode` plus a `brush` cursor-overlay flag, both pixel-aligned. It also services paint requests and full-canvas clears through a write-side FSM.

## Interface
- `CELL_SHIFT`, 2: log2 of cell edge in pixels (4×4 cells).
- `CANVAS_W`, 160: canvas width in cells.
- `CANVAS_H`, 120: canvas height in cells.
- `BRUSH_RADIUS`, 2: brush half-width in cells; the brush footprint is a (2R+1)² square.
- `clk  in  1`: pixel clock.
- `reset  in  1`: asynchronous, active-high.
- `x  in  10`: current pixel column, from the VGA timing generator.
- `y  in  10`: current pixel row.
- `visible  in  1`: pixel is in the active region.
- `brushX  in  8`: brush centre column, in cells.
- `brushY  in  7`: brush centre row, in cells.
- `paintValid  in  1`: request to paint the brush footprint.
- `paintColor  in  3`: colour code to paint.
- `paintReady  out  1`: paint request can be accepted.
- `clearReq  in  1`: single-cycle pulse; fills the canvas with ERASE.
- `busy  out  1`: a clear is in progress.
- `brush  out  1`: cursor overlay for the current pixel.
- `colorCode  out  3`: canvas code for the current pixel.
- `pixValid  out  1`: the delayed `visible`.

## Operation
- Read path: cell `cx = x>>CELL_SHIFT`, `cy = y>>CELL_SHIFT`; address `cy*CANVAS_W + cx` (15 bits, computed as `(cy<<7)+(cy<<5)+cx`).
  - When `!visible`, the address is forced to 0.
  - The read port is read-only and independent of writes.
- `brush` = 1 when `|cx-brushX| ≤ R` and `|cy-brushY| ≤ R`, using signed compare.
  - `brushX`/`brushY` are sampled in the same cycle as `x`/`y`.
  - `brush` is forced to 0 when `!visible`.
- When `!pixValid`, `colorCode` = ERASE and `brush` = 0.
- Write FSM has three states: IDLE, PAINT, CLEAR.
  - IDLE: `paintReady = !clearReq`.
    - `clearReq` goes to CLEAR. A clear takes priority over a simultaneous `paintValid`; the paint is not accepted.
    - `paintValid && paintReady` latches `brushX`, `brushY` and `paintColor`, then goes to PAINT.
  - PAINT: dx/dy counters sweep -R..R in row-major order, one cell per cycle, for (2R+1)² cycles.
    - Cells with cx∉[0,CANVAS_W-1] or cy∉[0,CANVAS_H-1] use their cycle but are not written. There is no wrap-around.
    - After the last cell, the FSM returns to IDLE.
  - CLEAR: a 15-bit counter writes ERASE to addresses 0..19199, one per cycle, then returns to IDLE.
    - `busy` = 1 only in CLEAR.
    - `clearReq` during PAINT is ignored. `clearReq` during CLEAR is ignored.
- Reset puts the FSM into CLEAR with the counter at 0, because RAM contents are undefined after power-up. Reset mid-paint abandons the paint and restarts the clear.
- Same-address read and write in one cycle: the read returns the old data (read-first).

## Timing
- Reset values:
  - `brush` = 0, `colorCode` = ERASE, `pixValid` = 0.
  - `paintReady` = 0, `busy` = 1.
  - State = CLEAR, counter = 0.
- Read latency is 2 cycles from `x`/`y`/`visible` to the outputs.
  - Cycle 0: address register.
  - Cycle 1: RAM output.
  - `brush`/`pixValid` are delayed through matching flops.
  - The VGA timing block delays hsync/vsync by 2 to match.
- Paint accepted at cycle t: writes occur in cycles t+1..t+(2R+1)². `paintReady` reasserts at t+(2R+1)²+1, i.e. t+26 with the defaults.
- Clear entered at cycle t: writes occur in cycles t+1..t+19200. `busy` falls at t+19201.

## Configuration
- `CANVAS_CURSOR_EN` defined: the `brush` overlay is computed as above.
- `CANVAS_CURSOR_EN` undefined: `brush` is tied to 0, and the compare logic and its delay flops are removed. Paint behaviour is unchanged.

## Structure
- Shared package holds:
  - `colorCode_t` enum: RED=3'd0, GREEN=1, BLUE=2, YELLOW=3, PURPLE=4, WHITE=5, ERASE=6.
  - The FSM state enum.
  - The canvas dimension constants.
- One sub-module, `canvasRam`: a simple dual-port RAM, 19200×3, with one synchronous read port and one write port, read-first, and no reset on its storage.

## Test plan
1. Release reset → `busy`=1 and `paintReady`=0 for 19200 cycles. Afterwards, every visible pixel reads `colorCode`=6.
2. Paint with brushX=10, brushY=10, paintColor=0 → cells 8..12 × 8..12 become RED.
   - x=32, y=32 gives `colorCode`=0 two cycles later.
   - x=52, y=32 gives 6.
   - `paintReady` returns 26 cycles after acceptance.
3. Paint with brushX=0, brushY=0 → only the 9 cells (0..2 × 0..2) are written. Cells (158..159, 118..119) stay 6. The sweep still takes 25 cycles.
4. `clearReq` and `paintValid` high in the same IDLE cycle → `paintReady`=0, the FSM enters CLEAR, and the paint is not taken. The cells of a prior paint read 6 after 19201 cycles.
5. With brushX=80, brushY=60, pixel x=320, y=240, visible → `brush`=1. Pixel x=340 gives `brush`=0. With `CANVAS_CURSOR_EN` undefined, `brush`=0 always. With visible=0, `pixValid`=0 and `colorCode`=6.
6. Assert reset 10 cycles into a paint → `busy`=1 immediately and the clear restarts from address 0. No further paint writes occur.
